// File: rtl/tdc_hw_stats.sv
// -----------------------------------------------------------------------------
// tdc_hw_stats
// Window statistics engine for TDC Hamming-weight samples. A start request
// discards FLUSH pipeline-flush cycles, then accumulates exactly 2^SAMPLE_LOG2
// valid samples. It presents the sum, mean, min and max behind a
// valid/ready handshake.
//
// Optional feature macro: TDC_HW_STATS_MINMAX_EN
//   defined   : min/max trackers are built
//   undefined : o_min_hw / o_max_hw are tied to 0
//
// Ports
//   i_clk            capture clock
//   i_rst            asynchronous active-high reset
//   i_en             global enable; when low, the FSM and all counters hold
//   i_start          single-cycle window request, honoured only in IDLE
//   i_hw             Hamming weight sample (HW_W bits)
//   i_hw_valid       i_hw is a valid sample this cycle
//   o_busy           window in progress (FLUSH or ACCUM)
//   o_result_valid   statistics available (HOLD)
//   i_result_ready   consumer accepts the result
//   o_sum            exact window sum (HW_W+SAMPLE_LOG2 bits)
//   o_mean           o_sum >> SAMPLE_LOG2, combinational from registered sum
//   o_min_hw         smallest sample in the window
//   o_max_hw         largest sample in the window
// -----------------------------------------------------------------------------
module tdc_hw_stats #(
  parameter int unsigned N           = 64,
  parameter int unsigned SAMPLE_LOG2 = 8,
  parameter int unsigned FLUSH       = 3
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_en,
  input  logic                            i_start,
  input  logic [$clog2(N):0]              i_hw,
  input  logic                            i_hw_valid,
  output logic                            o_busy,
  output logic                            o_result_valid,
  input  logic                            i_result_ready,
  output logic [$clog2(N)+SAMPLE_LOG2:0]  o_sum,
  output logic [$clog2(N):0]              o_mean,
  output logic [$clog2(N):0]              o_min_hw,
  output logic [$clog2(N):0]              o_max_hw
);

  localparam int unsigned HW_W   = $clog2(N) + 1;
  localparam int unsigned SUM_W  = HW_W + SAMPLE_LOG2;
  localparam int unsigned CNT_W  = SAMPLE_LOG2;
  localparam int unsigned FCNT_W = 4;

  // Window is full when the sample counter is all ones at the accepting edge.
  localparam logic [CNT_W-1:0]  CNT_LAST  = '1;
  // Unused when FLUSH is 0 (IDLE goes straight to ACCUM).
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FLUSH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FLUSH = 2'd1,
    S_ACCUM = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [SUM_W-1:0]    r_sum;
  logic [CNT_W-1:0]    r_cnt;
  logic [FCNT_W-1:0]   r_fcnt;

  logic w_start_ok;
  logic w_accept;
  logic w_last;
  logic w_flush_done;
  logic w_handshake;

  assign w_start_ok   = i_en && (r_state == S_IDLE) && i_start;
  assign w_accept     = i_en && (r_state == S_ACCUM) && i_hw_valid;
  assign w_last       = w_accept && (r_cnt == CNT_LAST);
  assign w_flush_done = i_en && (r_state == S_FLUSH) && (r_fcnt == FCNT_LAST);
  assign w_handshake  = i_en && (r_state == S_HOLD) && i_result_ready;

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; every transition term already carries i_en
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start_ok)   w_next = (FLUSH == 0) ? S_ACCUM : S_FLUSH;
      S_FLUSH: if (w_flush_done) w_next = S_ACCUM;
      S_ACCUM: if (w_last)       w_next = S_HOLD;
      S_HOLD:  if (w_handshake)  w_next = S_IDLE;
      default:                   w_next = S_IDLE;
    endcase
  end

  // Moore output decode of the registered state
  always_comb begin
    o_busy         = 1'b0;
    o_result_valid = 1'b0;
    case (r_state)
      S_FLUSH, S_ACCUM: o_busy         = 1'b1;
      S_HOLD:           o_result_valid = 1'b1;
      default:          ;
    endcase
  end

  // Flush counter, sample counter and accumulator; the accumulator is the sum output
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sum  <= '0;
      r_cnt  <= '0;
      r_fcnt <= '0;
    end else if (w_start_ok) begin
      r_sum  <= '0;
      r_cnt  <= '0;
      r_fcnt <= '0;
    end else if (i_en) begin
      if (r_state == S_FLUSH) r_fcnt <= r_fcnt + FCNT_W'(1);
      if (w_accept) begin
        r_sum <= r_sum + SUM_W'(i_hw);
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_sum  = r_sum;
  assign o_mean = HW_W'(r_sum >> SAMPLE_LOG2);

`ifdef TDC_HW_STATS_MINMAX_EN
  logic [HW_W-1:0] r_min;
  logic [HW_W-1:0] r_max;

  // Min starts at all ones and max at zero so the first sample wins both
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_min <= '0;
      r_max <= '0;
    end else if (w_start_ok) begin
      r_min <= '1;
      r_max <= '0;
    end else if (w_accept) begin
      if (i_hw < r_min) r_min <= i_hw;
      if (i_hw > r_max) r_max <= i_hw;
    end
  end

  assign o_min_hw = r_min;
  assign o_max_hw = r_max;
`else
  assign o_min_hw = '0;
  assign o_max_hw = '0;
`endif

endmodule

// File: tb/tb_tdc_hw_stats.sv
// -----------------------------------------------------------------------------
// tb_tdc_hw_stats
// Self-checking bench for tdc_hw_stats (N=64, SAMPLE_LOG2=2, FLUSH=3).
// Expected window results are pushed to a scoreboard queue when the samples
// are driven, then popped and compared when the DUT raises o_result_valid.
// Expected min/max follow TDC_HW_STATS_MINMAX_EN.
// -----------------------------------------------------------------------------
module tb_tdc_hw_stats;

  localparam int unsigned N     = 64;
  localparam int unsigned SL2   = 2;
  localparam int unsigned FL    = 3;
  localparam int unsigned HW_W  = 7;
  localparam int unsigned SUM_W = 9;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              start;
  logic [HW_W-1:0]   hw;
  logic              hw_valid;
  logic              ready;
  logic              busy;
  logic              rv;
  logic [SUM_W-1:0]  sum;
  logic [HW_W-1:0]   mean;
  logic [HW_W-1:0]   min_hw;
  logic [HW_W-1:0]   max_hw;

  tdc_hw_stats #(
    .N           (N),
    .SAMPLE_LOG2 (SL2),
    .FLUSH       (FL)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_en           (en),
    .i_start        (start),
    .i_hw           (hw),
    .i_hw_valid     (hw_valid),
    .o_busy         (busy),
    .o_result_valid (rv),
    .i_result_ready (ready),
    .o_sum          (sum),
    .o_mean         (mean),
    .o_min_hw       (min_hw),
    .o_max_hw       (max_hw)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned sum;
    int unsigned mn;
    int unsigned mx;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int unsigned exp_min(input int unsigned v);
`ifdef TDC_HW_STATS_MINMAX_EN
    return v;
`else
    return 0;
`endif
  endfunction

  // Start pulse followed by the flush cycles; flush-time stimulus must be discarded
  task automatic start_window(input int unsigned fl_hw, input logic fl_valid);
    start    = 1'b1;
    hw       = HW_W'(fl_hw);
    hw_valid = fl_valid;
    tick;
    start = 1'b0;
    repeat (FL) tick;
    hw_valid = 1'b0;
  endtask

  // Drive four samples with gap idle cycles between them and push the expectation
  task automatic feed(input int unsigned s[4], input int unsigned gap);
    exp_t e;
    e.sum = 0;
    e.mn  = 127;
    e.mx  = 0;
    for (int i = 0; i < 4; i++) begin
      e.sum += s[i];
      if (s[i] < e.mn) e.mn = s[i];
      if (s[i] > e.mx) e.mx = s[i];
    end
    e.mn = exp_min(e.mn);
    e.mx = exp_min(e.mx);
    sb.push_back(e);
    for (int i = 0; i < 4; i++) begin
      hw       = HW_W'(s[i]);
      hw_valid = 1'b1;
      tick;
      hw_valid = 1'b0;
      hw       = 7'd99;
      if (i < 3) begin
        for (int g = 0; g < int'(gap); g++) begin
          tick;
          check_val("gap_busy", 32'(busy), 1);
        end
      end
    end
  endtask

  // Wait (bounded) for a result and compare it against the scoreboard head
  task automatic collect(input string tag);
    exp_t e;
    int   n;
    n = 0;
    while (!rv && n < 100) begin
      tick;
      n++;
    end
    check_val({tag, "_rv"}, 32'(rv), 1);
    if (sb.size() == 0) begin
      check_val({tag, "_sb_empty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      check_val({tag, "_busy"}, 32'(busy), 0);
      check_val({tag, "_sum"},  32'(sum),  e.sum);
      check_val({tag, "_mean"}, 32'(mean), e.sum >> SL2);
      check_val({tag, "_min"},  32'(min_hw), e.mn);
      check_val({tag, "_max"},  32'(max_hw), e.mx);
    end
  endtask

  task automatic ack(input string tag);
    ready = 1'b1;
    tick;
    ready = 1'b0;
    check_val({tag, "_ack_rv"}, 32'(rv), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned arr[4];
    int          lat;

    rst = 1'b1; en = 1'b1; start = 1'b0; hw = '0; hw_valid = 1'b0; ready = 1'b0;
    repeat (3) tick;
    check_val("rst_busy", 32'(busy), 0);
    check_val("rst_rv",   32'(rv),   0);
    check_val("rst_sum",  32'(sum),  0);
    check_val("rst_mean", 32'(mean), 0);
    check_val("rst_min",  32'(min_hw), 0);
    check_val("rst_max",  32'(max_hw), 0);
    #2 rst = 1'b0;
    tick;

    // Constant 32 with continuous valid; result 7 cycles after start
    hw = 7'd32; hw_valid = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    check_val("t1_busy", 32'(busy), 1);
    lat = 0;
    while (!rv && lat < 100) begin
      tick;
      lat++;
    end
    check_val("t1_latency", 32'(lat), 7);
    sb.push_back('{sum: 128, mn: exp_min(32), mx: exp_min(32)});
    collect("t1");
    hw_valid = 1'b0;
    ack("t1");
    check_val("t1_idle_busy", 32'(busy), 0);
    check_val("t1_retain_sum", 32'(sum), 128);

    // Gapped samples; gap cycles carry a bogus hw that must be ignored
    start_window(0, 1'b0);
    arr = '{10, 20, 30, 40};
    feed(arr, 2);
    collect("t2");
    ack("t2");

    // Full-scale samples; flush cycles present valid hw=7 that must be discarded
    start_window(7, 1'b1);
    arr = '{64, 64, 64, 64};
    feed(arr, 0);
    collect("t3");
    ack("t3");

    // Long hold with a start pulse inside, then handshake with start in the same cycle
    start_window(0, 1'b0);
    arr = '{1, 2, 3, 4};
    feed(arr, 0);
    collect("t4");
    for (int i = 0; i < 20; i++) begin
      start = (i == 5);
      tick;
      check_val("t4_hold_rv",  32'(rv),  1);
      check_val("t4_hold_sum", 32'(sum), 10);
    end
    start = 1'b0;
    check_val("t4_hold_min", 32'(min_hw), exp_min(1));
    ready = 1'b1; start = 1'b1;
    tick;
    ready = 1'b0; start = 1'b0;
    check_val("t4_hs_rv",   32'(rv),   0);
    check_val("t4_hs_busy", 32'(busy), 0);
    check_val("t4_hs_sum",  32'(sum),  10);
    tick;
    check_val("t4_idle_busy", 32'(busy), 0);
    start = 1'b1;
    tick;
    start = 1'b0;
    check_val("t4_new_busy", 32'(busy), 1);
    check_val("t4_new_sum",  32'(sum),  0);
    check_val("t4_new_min",  32'(min_hw), exp_min(127));
    check_val("t4_new_max",  32'(max_hw), 0);
    repeat (FL) tick;
    arr = '{5, 6, 7, 8};
    feed(arr, 0);
    collect("t4b");
    ack("t4b");

    // Asynchronous reset after two accepted samples
    start_window(0, 1'b0);
    hw = 7'd50; hw_valid = 1'b1;
    tick;
    tick;
    check_val("t5_partial", 32'(sum), 100);
    #2 rst = 1'b1;
    #1;
    check_val("t5_rst_sum",  32'(sum),  0);
    check_val("t5_rst_mean", 32'(mean), 0);
    check_val("t5_rst_min",  32'(min_hw), 0);
    check_val("t5_rst_max",  32'(max_hw), 0);
    check_val("t5_rst_busy", 32'(busy), 0);
    check_val("t5_rst_rv",   32'(rv),   0);
    hw_valid = 1'b0;
    tick;
    #2 rst = 1'b0;
    tick;
    start_window(0, 1'b0);
    arr = '{100, 0, 17, 3};
    feed(arr, 0);
    collect("t5");
    ack("t5");

    // Enable low freezes accumulation and the HOLD handshake
    start_window(0, 1'b0);
    sb.push_back('{sum: 100, mn: exp_min(10), mx: exp_min(40)});
    hw = 7'd10; hw_valid = 1'b1;
    tick;
    en = 1'b0; hw = 7'd100;
    repeat (3) tick;
    check_val("t6_frz_busy", 32'(busy), 1);
    check_val("t6_frz_sum",  32'(sum),  10);
    en = 1'b1;
    hw = 7'd20; tick;
    hw = 7'd30; tick;
    hw = 7'd40; tick;
    hw_valid = 1'b0;
    collect("t6");
    en = 1'b0; ready = 1'b1;
    tick;
    check_val("t6_frz_hold", 32'(rv), 1);
    en = 1'b1;
    tick;
    ready = 1'b0;
    check_val("t6_ack_rv", 32'(rv), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
